// File: rtl/control_fsm.sv
// Multicycle RISC-V main controller: Moore state machine sequencing fetch, decode,
// memory, ALU, branch and jump steps, with an opcode-driven immediate selector.
module control_fsm #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t r_state;
  state_t w_next_state;
  logic   w_pc_update;
  logic   w_branch;
  logic   w_ir_write;
  logic   w_mem_write;
  logic   w_reg_write;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values of its inputs regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // NOTE: each combinational block assigns a default to every output first, so
  // no path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXECUTER;
          OP_ITYPE:          w_next_state = S_EXECUTEI;
          OP_BEQ:            w_next_state = S_BEQ;
          OP_JAL:            w_next_state = S_JAL;
          default:           w_next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   w_next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next_state = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      w_next_state = S_ALUWB;
      S_HALT:     w_next_state = S_HALT;
      default:    w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_ir_write  = 1'b1;
        w_pc_update = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        w_branch = 1'b1;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are masked by reset so an interrupted instruction commits nothing.
  assign PCWrite  = (w_pc_update | (w_branch & Zero)) & ~reset;
  assign IRWrite  = w_ir_write  & ~reset;
  assign MemWrite = w_mem_write & ~reset;
  assign RegWrite = w_reg_write & ~reset;
  assign state    = r_state;

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BEQ:   ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: one instance per ILLEGAL_HALT setting, shared
// stimulus, outputs checked half a cycle after each rising edge.
module tb_control_fsm;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op    = 7'd0;
  logic       Zero  = 1'b0;

  logic       PCWrite0, AdrSrc0, IRWrite0, MemWrite0, RegWrite0;
  logic [1:0] ResultSrc0, ALUSrcA0, ALUSrcB0, ALUOp0, ImmSrc0;
  logic [3:0] state0;
  logic       PCWrite1, AdrSrc1, IRWrite1, MemWrite1, RegWrite1;
  logic [1:0] ResultSrc1, ALUSrcA1, ALUSrcB1, ALUOp1, ImmSrc1;
  logic [3:0] state1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  control_fsm #(.ILLEGAL_HALT(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero),
    .PCWrite(PCWrite0), .AdrSrc(AdrSrc0), .IRWrite(IRWrite0), .MemWrite(MemWrite0),
    .RegWrite(RegWrite0), .ResultSrc(ResultSrc0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0),
    .ALUOp(ALUOp0), .ImmSrc(ImmSrc0), .state(state0)
  );

  control_fsm #(.ILLEGAL_HALT(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero),
    .PCWrite(PCWrite1), .AdrSrc(AdrSrc1), .IRWrite(IRWrite1), .MemWrite(MemWrite1),
    .RegWrite(RegWrite1), .ResultSrc(ResultSrc1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1),
    .ALUOp(ALUOp1), .ImmSrc(ImmSrc1), .state(state1)
  );

  // {AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
  logic [11:0] ctl0, ctl1;
  assign ctl0 = {AdrSrc0, IRWrite0, MemWrite0, RegWrite0, ResultSrc0, ALUSrcA0, ALUSrcB0, ALUOp0};
  assign ctl1 = {AdrSrc1, IRWrite1, MemWrite1, RegWrite1, ResultSrc1, ALUSrcA1, ALUSrcB1, ALUOp1};

  localparam logic [11:0] CTL_FETCH_RST = 12'b0000_10_00_10_00;

  function automatic logic [11:0] exp_ctl(input logic [3:0] s);
    case (s)
      4'd0:    return 12'b0100_10_00_10_00;
      4'd1:    return 12'b0000_00_01_01_00;
      4'd2:    return 12'b0000_00_10_01_00;
      4'd3:    return 12'b1000_00_00_00_00;
      4'd4:    return 12'b0001_01_00_00_00;
      4'd5:    return 12'b1010_00_00_00_00;
      4'd6:    return 12'b0000_00_10_00_10;
      4'd7:    return 12'b0000_00_10_01_10;
      4'd8:    return 12'b0001_00_00_00_00;
      4'd9:    return 12'b0000_00_10_00_01;
      4'd10:   return 12'b0000_00_01_10_00;
      default: return 12'b0000_00_00_00_00;
    endcase
  endfunction

  function automatic logic exp_pcw(input logic [3:0] s, input logic z);
    if (s == 4'd0 || s == 4'd10) return 1'b1;
    if (s == 4'd9)               return z;
    return 1'b0;
  endfunction

  // State sequence packed as hex nibbles, first state in the top nibble.
  typedef struct {
    string       name;
    logic [6:0]  op;
    logic        z;
    logic [1:0]  imm;
    int          len;
    logic [23:0] seq;
  } vec_t;

  task automatic test_reset();
    #12;
    n_tests++;
    if (state0 !== 4'd0 || state1 !== 4'd0 || ctl0 !== CTL_FETCH_RST || PCWrite0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: state=%0d ctl=%b pcw=%b, want state=0 ctl=%b pcw=0",
               state0, ctl0, PCWrite0, CTL_FETCH_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    op    = 7'b0000011;
    #1;
    n_tests++;
    if (state0 !== 4'd0 || state1 !== 4'd0 || ctl0 !== exp_ctl(4'd0) || PCWrite0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d ctl=%b pcw=%b, want state=0 ctl=%b pcw=1",
               state0, ctl0, PCWrite0, exp_ctl(4'd0));
    end
  endtask

  task automatic test_mem();
    vec_t tbl [2];
    tbl[0] = '{name: "lw", op: 7'b0000011, z: 1'b0, imm: 2'b00, len: 6, seq: 24'h012340};
    tbl[1] = '{name: "sw", op: 7'b0100011, z: 1'b0, imm: 2'b01, len: 5, seq: 24'h012500};
    for (int v = 0; v < 2; v++) begin
      op   = tbl[v].op;
      Zero = tbl[v].z;
      for (int i = 0; i < tbl[v].len; i++) begin
        logic [3:0] s;
        if (i > 0) @(negedge clk);
        #1;
        s = tbl[v].seq[23-4*i -: 4];
        n_tests++;
        if (state0 !== s || state1 !== s || ctl0 !== exp_ctl(s) ||
            PCWrite0 !== exp_pcw(s, tbl[v].z) || ImmSrc0 !== tbl[v].imm) begin
          n_fail++;
          $display("FAIL %s step %0d: state=%0d/%0d ctl=%b pcw=%b imm=%b, want state=%0d ctl=%b pcw=%b imm=%b",
                   tbl[v].name, i, state0, state1, ctl0, PCWrite0, ImmSrc0,
                   s, exp_ctl(s), exp_pcw(s, tbl[v].z), tbl[v].imm);
        end
      end
    end
  endtask

  task automatic test_alu();
    vec_t tbl [3];
    tbl[0] = '{name: "rtype", op: 7'b0110011, z: 1'b0, imm: 2'b00, len: 5, seq: 24'h016800};
    tbl[1] = '{name: "itype", op: 7'b0010011, z: 1'b1, imm: 2'b00, len: 5, seq: 24'h017800};
    tbl[2] = '{name: "jal",   op: 7'b1101111, z: 1'b0, imm: 2'b11, len: 5, seq: 24'h01A800};
    for (int v = 0; v < 3; v++) begin
      op   = tbl[v].op;
      Zero = tbl[v].z;
      for (int i = 0; i < tbl[v].len; i++) begin
        logic [3:0] s;
        if (i > 0) @(negedge clk);
        #1;
        s = tbl[v].seq[23-4*i -: 4];
        n_tests++;
        if (state0 !== s || state1 !== s || ctl0 !== exp_ctl(s) ||
            PCWrite0 !== exp_pcw(s, tbl[v].z) || ImmSrc0 !== tbl[v].imm) begin
          n_fail++;
          $display("FAIL %s step %0d: state=%0d/%0d ctl=%b pcw=%b imm=%b, want state=%0d ctl=%b pcw=%b imm=%b",
                   tbl[v].name, i, state0, state1, ctl0, PCWrite0, ImmSrc0,
                   s, exp_ctl(s), exp_pcw(s, tbl[v].z), tbl[v].imm);
        end
      end
    end
  endtask

  task automatic test_branch();
    vec_t tbl [2];
    tbl[0] = '{name: "beq_taken",     op: 7'b1100011, z: 1'b1, imm: 2'b10, len: 4, seq: 24'h019000};
    tbl[1] = '{name: "beq_not_taken", op: 7'b1100011, z: 1'b0, imm: 2'b10, len: 4, seq: 24'h019000};
    for (int v = 0; v < 2; v++) begin
      op   = tbl[v].op;
      Zero = tbl[v].z;
      for (int i = 0; i < tbl[v].len; i++) begin
        logic [3:0] s;
        if (i > 0) @(negedge clk);
        #1;
        s = tbl[v].seq[23-4*i -: 4];
        n_tests++;
        if (state0 !== s || state1 !== s || ctl0 !== exp_ctl(s) ||
            PCWrite0 !== exp_pcw(s, tbl[v].z) || ImmSrc0 !== tbl[v].imm) begin
          n_fail++;
          $display("FAIL %s step %0d: state=%0d/%0d ctl=%b pcw=%b imm=%b, want state=%0d ctl=%b pcw=%b imm=%b",
                   tbl[v].name, i, state0, state1, ctl0, PCWrite0, ImmSrc0,
                   s, exp_ctl(s), exp_pcw(s, tbl[v].z), tbl[v].imm);
        end
      end
    end
    Zero = 1'b0;
  endtask

  // Unknown opcode: instance 0 recycles through FETCH, instance 1 parks in HALT.
  task automatic test_illegal();
    logic [3:0] s0, s1;
    op   = 7'b1111111;
    Zero = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      s0 = (i % 2 == 0) ? 4'd0 : 4'd1;
      s1 = (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : 4'd11;
      n_tests++;
      if (state0 !== s0 || ctl0 !== exp_ctl(s0) || PCWrite0 !== exp_pcw(s0, 1'b1) ||
          state1 !== s1 || ctl1 !== exp_ctl(s1) || PCWrite1 !== exp_pcw(s1, 1'b1) ||
          ImmSrc1 !== 2'b00) begin
        n_fail++;
        $display("FAIL illegal step %0d: st0=%0d ctl0=%b pcw0=%b st1=%0d ctl1=%b pcw1=%b imm1=%b, want st0=%0d st1=%0d ctl1=%b",
                 i, state0, ctl0, PCWrite0, state1, ctl1, PCWrite1, ImmSrc1, s0, s1, exp_ctl(s1));
      end
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (state1 !== 4'd0 || ctl1 !== CTL_FETCH_RST || PCWrite1 !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_async_reset: state=%0d ctl=%b pcw=%b, want state=0 ctl=%b pcw=0",
               state1, ctl1, PCWrite1, CTL_FETCH_RST);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (state1 !== 4'd0 || state0 !== 4'd0 || ctl1 !== CTL_FETCH_RST || PCWrite1 !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_reset_hold: state=%0d/%0d ctl=%b pcw=%b, want state=0 ctl=%b pcw=0",
               state0, state1, ctl1, PCWrite1, CTL_FETCH_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    Zero  = 1'b0;
    #1;
    n_tests++;
    if (state1 !== 4'd0 || ctl1 !== exp_ctl(4'd0) || PCWrite1 !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_release: state=%0d ctl=%b pcw=%b, want state=0 ctl=%b pcw=1",
               state1, ctl1, PCWrite1, exp_ctl(4'd0));
    end
  endtask

  // Reset mid-cycle while a load sits in MEMREAD, then restart cleanly.
  task automatic test_reset_midcycle();
    op = 7'b0000011;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (state0 !== 4'd3 || state1 !== 4'd3) begin
      n_fail++;
      $display("FAIL reach_memread: state=%0d/%0d, want 3", state0, state1);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (state0 !== 4'd0 || ctl0 !== CTL_FETCH_RST || PCWrite0 !== 1'b0) begin
      n_fail++;
      $display("FAIL memread_async_reset: state=%0d ctl=%b pcw=%b, want state=0 ctl=%b pcw=0",
               state0, ctl0, PCWrite0, CTL_FETCH_RST);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (state0 !== 4'd0 || ctl0 !== CTL_FETCH_RST || PCWrite0 !== 1'b0) begin
      n_fail++;
      $display("FAIL memread_reset_hold: state=%0d ctl=%b pcw=%b, want state=0 ctl=%b pcw=0",
               state0, ctl0, PCWrite0, CTL_FETCH_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (state0 !== 4'd0 || ctl0 !== exp_ctl(4'd0) || PCWrite0 !== 1'b1) begin
      n_fail++;
      $display("FAIL midcycle_release: state=%0d ctl=%b pcw=%b, want state=0 ctl=%b pcw=1",
               state0, ctl0, PCWrite0, exp_ctl(4'd0));
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (state0 !== 4'd1 || ctl0 !== exp_ctl(4'd1) || PCWrite0 !== 1'b0) begin
      n_fail++;
      $display("FAIL first_edge_after_reset: state=%0d ctl=%b pcw=%b, want state=1 ctl=%b pcw=0",
               state0, ctl0, PCWrite0, exp_ctl(4'd1));
    end
  endtask

  initial begin
    test_reset();
    test_mem();
    test_alu();
    test_branch();
    test_illegal();
    test_reset_midcycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
